// File: rtl/pulse_shaper_if.sv
// Sample-stream bundle between the upsampler, the pulse-shaping FIR and the DAC side.
// master drives the zero-stuffed I/Q input; slave produces the filtered, saturated output.
interface pulse_shaper_if #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 10
);
  logic                    in_valid;
  logic signed [IN_W-1:0]  iup;
  logic signed [IN_W-1:0]  qup;
  logic                    out_valid;
  logic signed [OUT_W-1:0] iout;
  logic signed [OUT_W-1:0] qout;
  logic                    sat_i;
  logic                    sat_q;

  modport master (
    output in_valid, iup, qup,
    input  out_valid, iout, qout, sat_i, sat_q
  );

  modport slave (
    input  in_valid, iup, qup,
    output out_valid, iout, qout, sat_i, sat_q
  );
endinterface

// File: rtl/pulse_shaper.sv
// 16-tap symmetric FIR pulse shaper for the I/Q transmit path: pre-add/multiply stage, sum/scale/saturate stage.
// Optional build macro PSF_ROUND_EN: round half-up before the arithmetic right shift instead of flooring.
module pulse_shaper #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 10,
  parameter int unsigned SHIFT = 3
) (
  input  logic          clk,
  input  logic          reset,
  pulse_shaper_if.slave psf
);

  localparam int unsigned TAPS   = 16;
  localparam int unsigned HALF   = TAPS / 2;
  localparam int unsigned COEF_W = 8;
  localparam int unsigned PA_W   = IN_W + 1;
  localparam int unsigned PR_W   = PA_W + COEF_W;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned EXT_W  = 32;
  localparam int signed   SAT_MAX = (2 ** (OUT_W - 1)) - 1;
  localparam int signed   SAT_MIN = -(2 ** (OUT_W - 1));
`ifdef PSF_ROUND_EN
  localparam int signed   RND = (SHIFT > 0) ? (int'(1) << (SHIFT - 1)) : 0;
`else
  localparam int signed   RND = 0;
`endif

  // First half of the symmetric impulse response; tap k pairs with tap TAPS-1-k.
  function automatic logic signed [COEF_W-1:0] coef(input int unsigned k);
    case (k)
      0:       coef = 8'sd1;
      1:       coef = -8'sd2;
      2:       coef = -8'sd3;
      3:       coef = 8'sd0;
      4:       coef = 8'sd8;
      5:       coef = 8'sd20;
      6:       coef = 8'sd32;
      default: coef = 8'sd40;
    endcase
  endfunction

  logic in_v_q;
  logic s1_v_q;
  logic out_v_q;

  // Valid travels alongside the data: accept -> products -> output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_v_q  <= 1'b0;
      s1_v_q  <= 1'b0;
      out_v_q <= 1'b0;
    end else begin
      in_v_q  <= psf.in_valid;
      s1_v_q  <= in_v_q;
      out_v_q <= s1_v_q;
    end
  end

  logic signed [IN_W-1:0]  ch_x    [2];
  logic signed [OUT_W-1:0] ch_y    [2];
  logic                    ch_clip [2];

  assign ch_x[0] = psf.iup;
  assign ch_x[1] = psf.qup;

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic signed [IN_W-1:0]  dl_q   [TAPS];
    logic signed [PR_W-1:0]  prod_d [HALF];
    logic signed [PR_W-1:0]  prod_q [HALF];
    logic signed [ACC_W-1:0] acc_c;
    logic signed [EXT_W-1:0] scl_c;
    logic signed [OUT_W-1:0] y_d;
    logic signed [OUT_W-1:0] y_q;
    logic                    clip_d;
    logic                    clip_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int unsigned k = 0; k < TAPS; k++) dl_q[k] <= '0;
      end else if (psf.in_valid) begin
        dl_q[0] <= ch_x[ch];
        for (int unsigned k = 1; k < TAPS; k++) dl_q[k] <= dl_q[k-1];
      end
    end

    // Symmetric pre-add halves the multiplier count.
    always_comb begin
      for (int unsigned k = 0; k < HALF; k++) begin
        prod_d[k] = PR_W'(PA_W'(dl_q[k]) + PA_W'(dl_q[TAPS-1-k])) * PR_W'(coef(k));
      end
    end

    // Products only change when a new sample entered the delay line.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int unsigned k = 0; k < HALF; k++) prod_q[k] <= '0;
      end else if (in_v_q) begin
        prod_q <= prod_d;
      end
    end

    always_comb begin
      acc_c = '0;
      for (int unsigned k = 0; k < HALF; k++) begin
        acc_c = acc_c + ACC_W'(prod_q[k]);
      end
      scl_c  = (EXT_W'(acc_c) + EXT_W'(RND)) >>> SHIFT;
      y_d    = OUT_W'(scl_c);
      clip_d = 1'b0;
      if (scl_c > EXT_W'(SAT_MAX)) begin
        y_d    = OUT_W'(SAT_MAX);
        clip_d = 1'b1;
      end else if (scl_c < EXT_W'(SAT_MIN)) begin
        y_d    = OUT_W'(SAT_MIN);
        clip_d = 1'b1;
      end
    end

    // Output and clip flag hold between valid samples.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        y_q    <= '0;
        clip_q <= 1'b0;
      end else if (s1_v_q) begin
        y_q    <= y_d;
        clip_q <= clip_d;
      end
    end

    assign ch_y[ch]    = y_q;
    assign ch_clip[ch] = clip_q;
  end

  assign psf.out_valid = out_v_q;
  assign psf.iout      = ch_y[0];
  assign psf.qout      = ch_y[1];
  assign psf.sat_i     = ch_clip[0];
  assign psf.sat_q     = ch_clip[1];

endmodule

// File: tb/tb_pulse_shaper.sv
// Bench for pulse_shaper: three instances (defaults, SHIFT=0, OUT_W=8) driven in lockstep,
// checked against a direct-convolution reference model plus spec constant vectors.
module tb_pulse_shaper;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pulse_shaper_if #(.IN_W(4), .OUT_W(10)) if0 ();
  pulse_shaper_if #(.IN_W(4), .OUT_W(10)) if1 ();
  pulse_shaper_if #(.IN_W(4), .OUT_W(8))  if2 ();

  pulse_shaper #(.IN_W(4), .OUT_W(10), .SHIFT(3)) u_d0 (.clk(clk), .reset(rst_n), .psf(if0));
  pulse_shaper #(.IN_W(4), .OUT_W(10), .SHIFT(0)) u_d1 (.clk(clk), .reset(rst_n), .psf(if1));
  pulse_shaper #(.IN_W(4), .OUT_W(8),  .SHIFT(3)) u_d2 (.clk(clk), .reset(rst_n), .psf(if2));

`ifdef PSF_ROUND_EN
  localparam int TAP20_EXP = 3;
  localparam int TAPM3_EXP = 0;
  localparam int FIRST7_EXP = 1;
`else
  localparam int TAP20_EXP = 2;
  localparam int TAPM3_EXP = -1;
  localparam int FIRST7_EXP = 0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int hseq [16] = '{1, -2, -3, 0, 8, 20, 32, 40, 40, 32, 20, 8, 0, -3, -2, 1};
  int sh   [3]  = '{3, 0, 3};
  int ow   [3]  = '{10, 10, 8};

  int hist_i [16];
  int hist_q [16];

  typedef struct {
    int due;
    int acc_i;
    int acc_q;
  } exp_t;
  exp_t pend[$];

  int last_i [3];
  int last_q [3];
  int last_si[3];
  int last_sq[3];

  typedef struct {
    bit v;
    int i;
    int q;
    int eov;
    int ei;
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int floor_pow2(input int a, input int s);
    int d;
    d = 1 << s;
    return (a - (((a % d) + d) % d)) / d;
  endfunction

  function automatic void scale_sat(input int acc, input int d, output int y, output int c);
    int a;
    int hi;
    int lo;
    a  = acc;
    hi = (1 << (ow[d] - 1)) - 1;
    lo = -(1 << (ow[d] - 1));
`ifdef PSF_ROUND_EN
    if (sh[d] > 0) a = a + (1 << (sh[d] - 1));
`endif
    y = floor_pow2(a, sh[d]);
    c = 0;
    if (y > hi) begin
      y = hi;
      c = 1;
    end else if (y < lo) begin
      y = lo;
      c = 1;
    end
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 16; k++) begin
      hist_i[k] = 0;
      hist_q[k] = 0;
    end
    pend.delete();
    for (int d = 0; d < 3; d++) begin
      last_i[d] = 0; last_q[d] = 0; last_si[d] = 0; last_sq[d] = 0;
    end
  endtask

  task automatic drive(input bit v, input int i, input int q);
    if0.in_valid = v; if0.iup = 4'(i); if0.qup = 4'(q);
    if1.in_valid = v; if1.iup = 4'(i); if1.qup = 4'(q);
    if2.in_valid = v; if2.iup = 4'(i); if2.qup = 4'(q);
  endtask

  task automatic sample_and_check();
    int av[3], ai[3], aq[3], asi[3], asq[3];
    bit ev;
    av[0] = int'(if0.out_valid); ai[0] = int'(if0.iout); aq[0] = int'(if0.qout);
    asi[0] = int'(if0.sat_i); asq[0] = int'(if0.sat_q);
    av[1] = int'(if1.out_valid); ai[1] = int'(if1.iout); aq[1] = int'(if1.qout);
    asi[1] = int'(if1.sat_i); asq[1] = int'(if1.sat_q);
    av[2] = int'(if2.out_valid); ai[2] = int'(if2.iout); aq[2] = int'(if2.qout);
    asi[2] = int'(if2.sat_i); asq[2] = int'(if2.sat_q);
    ev = (pend.size() > 0) && (pend[0].due == cyc);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d out_valid", d), av[d], int'(ev));
      if (ev) begin
        scale_sat(pend[0].acc_i, d, last_i[d], last_si[d]);
        scale_sat(pend[0].acc_q, d, last_q[d], last_sq[d]);
      end
      chk($sformatf("d%0d iout", d), ai[d], last_i[d]);
      chk($sformatf("d%0d qout", d), aq[d], last_q[d]);
      chk($sformatf("d%0d sat_i", d), asi[d], last_si[d]);
      chk($sformatf("d%0d sat_q", d), asq[d], last_sq[d]);
    end
    if (ev) void'(pend.pop_front());
  endtask

  // One clock: drive, let the edge happen, update the model on acceptance, check 1 time unit later.
  task automatic step(input bit v, input int i, input int q);
    exp_t e;
    drive(v, i, q);
    @(posedge clk);
    cyc++;
    if (rst_n && v) begin
      for (int k = 15; k > 0; k--) begin
        hist_i[k] = hist_i[k-1];
        hist_q[k] = hist_q[k-1];
      end
      hist_i[0] = i;
      hist_q[0] = q;
      e.due = cyc + 2;
      e.acc_i = 0;
      e.acc_q = 0;
      for (int k = 0; k < 16; k++) begin
        e.acc_i += hseq[k] * hist_i[k];
        e.acc_q += hseq[k] * hist_q[k];
      end
      pend.push_back(e);
    end
    #1;
    sample_and_check();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    reset_model();
    sample_and_check();
    step(1'b0, 0, 0);
    step(1'b1, 7, 7);
    rst_n = 1'b1;
  endtask

  int rv;
  int rq;
  int pulses;
  int gv[7];
  int gi[7];

  initial begin
    for (int r = 0; r < 20; r++) begin
      tbl[r].v   = 1'b1;
      tbl[r].i   = (r == 0) ? 1 : 0;
      tbl[r].q   = 0;
      tbl[r].eov = (r >= 2) ? 1 : 0;
      tbl[r].ei  = (r >= 2 && r < 18) ? hseq[r-2] : 0;
    end
    gv = '{1, 0, 0, 1, 0, 0, 0};
    gi = '{3, 0, 0, 5, 0, 0, 0};

    reset_model();
    drive(1'b0, 0, 0);
    #1 rst_n = 1'b0;
    #1 sample_and_check();
    step(1'b0, 0, 0);
    step(1'b1, 5, 5);
    rst_n = 1'b1;

    // Impulse through the SHIFT=0 instance reproduces the coefficient list.
    for (int r = 0; r < 20; r++) begin
      step(tbl[r].v, tbl[r].i, tbl[r].q);
      chk($sformatf("tbl%0d d1 out_valid", r), int'(if1.out_valid), tbl[r].eov);
      chk($sformatf("tbl%0d d1 iout", r), int'(if1.iout), tbl[r].ei);
      chk($sformatf("tbl%0d d1 qout", r), int'(if1.qout), 0);
      if (r == 7) chk("d0 tap h=20", int'(if0.iout), TAP20_EXP);
      if (r == 4) chk("d0 tap h=-3", int'(if0.iout), TAPM3_EXP);
    end

    // DC step to steady state.
    do_reset();
    for (int n = 0; n < 20; n++) step(1'b1, 7, -8);
    chk("dc iout", int'(if0.iout), 168);
    chk("dc qout", int'(if0.qout), -192);
    chk("dc sat_i", int'(if0.sat_i), 0);
    chk("dc sat_q", int'(if0.sat_q), 0);

    // Reset in the middle of the DC run, then refill from zero history.
    for (int n = 0; n < 3; n++) step(1'b1, 7, 0);
    do_reset();
    step(1'b1, 7, 0);
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    chk("post-reset out_valid", int'(if0.out_valid), 1);
    chk("post-reset first iout", int'(if0.iout), FIRST7_EXP);
    for (int n = 0; n < 20; n++) step(1'b1, 7, 0);

    // Valid gaps: 1,0,0,1 with 3,x,x,5.
    do_reset();
    pulses = 0;
    gi[1] = int'($urandom_range(0, 15)) - 8;
    gi[2] = int'($urandom_range(0, 15)) - 8;
    for (int n = 0; n < 7; n++) begin
      step(gv[n] != 0, gi[n], 0);
      pulses += int'(if1.out_valid);
      if (n == 2) chk("gap first d1 iout", int'(if1.iout), 3);
      if (n == 5) chk("gap second d1 iout", int'(if1.iout), -1);
    end
    chk("gap pulse count", pulses, 2);

    // Worst-case negative accumulator into the OUT_W=8 instance.
    do_reset();
    for (int j = 0; j < 16; j++) begin
      rv = (hseq[15-j] > 0) ? -8 : ((hseq[15-j] < 0) ? 7 : 0);
      step(1'b1, rv, 0);
    end
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    chk("sat d2 iout", int'(if2.iout), -128);
    chk("sat d2 sat_i", int'(if2.sat_i), 1);
    chk("sat d2 qout", int'(if2.qout), 0);
    chk("sat d2 sat_q", int'(if2.sat_q), 0);

    // Random traffic with gaps.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rv = int'($urandom_range(0, 15)) - 8;
      rq = int'($urandom_range(0, 15)) - 8;
      step($urandom_range(0, 3) != 0, rv, rq);
    end
    // Extreme values to exercise clipping on the narrow and unshifted instances.
    for (int n = 0; n < 150; n++) begin
      rv = ($urandom_range(0, 1) != 0) ? 7 : -8;
      rq = ($urandom_range(0, 1) != 0) ? 7 : -8;
      step($urandom_range(0, 4) != 0, rv, rq);
    end
    for (int n = 0; n < 4; n++) step(1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_shaper.md
Name: pulse_shaper

Overview:
- 16-tap FIR pulse-shaping filter in the qam16 transmit chain, directly downstream of the upsampler.
- Consumes the zero-stuffed I/Q streams (iup/qup) and produces band-limited I/Q samples for the DAC interface.
- Two identical fixed-coefficient datapaths (I and Q), a two-stage pipeline, and a scaled, saturated output.

Parameters:
- IN_W, 4, signed input sample width (matches upsampler iup/qup).
- OUT_W, 10, signed output sample width.
- SHIFT, 3, arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  iup/qup carry a sample this cycle.
- iup  input  IN_W  signed upsampled I sample.
- qup  input  IN_W  signed upsampled Q sample.
- out_valid  output  1  iout/qout updated this cycle.
- iout  output  OUT_W  signed filtered I sample.
- qout  output  OUT_W  signed filtered Q sample.
- sat_i  output  1  iout was clipped this sample.
- sat_q  output  1  qout was clipped this sample.

Behaviour:
- Reset (reset=0, asynchronous): delay lines, product registers and accumulators clear to 0; out_valid, iout, qout, sat_i and sat_q all clear to 0.
- Reset mid-stream: in-flight samples are discarded. After release, filtering restarts with zero history.
- Coefficients are fixed, signed 8-bit, symmetric, h[0..15] = 1,-2,-3,0,8,20,32,40,40,32,20,8,0,-3,-2,1 (sum 192, sum|h| 212).
- Delay line:
  - 16 entries per channel.
  - On a clk edge with in_valid=1: entry0 <= input, entry k <= entry k-1.
  - With in_valid=0 the delay line holds.
- Stage 1: the 8 symmetric pre-adds (x[k]+x[15-k]) are multiplied by h[k]. Products are registered and valid_s1 <= in_valid of the prior cycle.
- Stage 2: the 8 products are summed into a 16-bit signed accumulator, then scaled, saturated and registered to iout/qout. out_valid <= valid_s1.
- Latency: the sample accepted at edge N first affects iout/qout at edge N+2. out_valid is high for exactly one cycle per accepted sample.
- Throughput: one sample per clock. Back-to-back in_valid is fully supported.
- When out_valid=0, iout/qout/sat_i/sat_q hold their last values.
- Scaling: y = acc >>> SHIFT (floor, arithmetic shift).
- Saturation:
  - If y > 2^(OUT_W-1)-1: output the maximum and assert sat for that sample.
  - If y < -2^(OUT_W-1): output the minimum and assert sat for that sample.
  - Otherwise sat=0.
- With defaults no saturation is possible (|acc| ≤ 8·212 = 1696, giving |y| ≤ 212).
- I and Q are independent. Saturation on one channel does not affect the other.

Optional Feature:
- Macro: PSF_ROUND_EN.
- Defined: round half-up before the shift, y = (acc + 2^(SHIFT-1)) >>> SHIFT. Saturation is applied after rounding. For SHIFT=0 the result equals acc.
- Undefined: pure floor shift as above.
- Ports and latency are identical in both builds.

Test Plan:
- Impulse, SHIFT=0 instance: iup=+1 for one valid cycle, then iup=0 with in_valid=1 continuously → iout sequence 1,-2,-3,0,8,20,32,40,40,32,20,8,0,-3,-2,1,0…; first value appears 2 cycles after acceptance; qout=0 throughout.
- DC step, defaults: iup=7, qup=-8 valid every cycle → after 16 samples iout=168 and qout=-192 steady; sat_i=sat_q=0.
- Rounding, defaults, iup impulse +1: without PSF_ROUND_EN the tap outputs for h=20 and h=-3 are 2 and -1; with PSF_ROUND_EN they are 3 and 0.
- Saturation, OUT_W=8, SHIFT=3: drive the I delay line with the pattern that maximises |acc| (-8 where h>0, +7 where h<0) → iout=-128 with sat_i=1 on that sample; qup=0 gives qout=0 and sat_q=0.
- Valid gaps: in_valid toggles 1,0,0,1 with iup=3,x,x,5 → exactly two out_valid pulses, 2 cycles after each accepted sample; outputs hold between pulses; results match the gap-free sequence 3,5.
- Reset mid-stream: assert reset during a DC run of iup=7 → all outputs 0 immediately. After release, one valid iup=7 → first out_valid shows floor(7·1/8)=0, and the output rises as history refills with no stale samples.
